pipe_msgbus_phy_responder: RTL

- PHY-side responder for the PIPE 8-bit message bus.
- Decodes MAC-to-PHY transactions on m2p_message_bus: write_uncommitted, write_committed and read.
- Holds an internal register file and a buffer for uncommitted writes.
- Drives PHY-to-MAC write_ack and read_completion on p2m_message_bus; the same cdn_message_bus agent monitors this traffic on the PHY end.

---
 rtl/pipe_msgbus_phy_responder.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_msgbus_phy_responder.sv
// rtl/pipe_msgbus_phy_responder.sv - PIPE 8-bit message bus PHY-side responder
//
// Decodes MAC-to-PHY write_uncommitted / write_committed / read transactions,
// keeps a small register file plus a FIFO of uncommitted writes, and answers
// with write_ack (8'h50) and read_completion (8'h40, data) on the PHY-to-MAC bus.
//
// Ports:
//   pclk             PIPE clock, all logic on its rising edge
//   reset            asynchronous active-low reset
//   m2p_message_bus  MAC-to-PHY bus, 8'h00 = NOP
//   p2m_message_bus  PHY-to-MAC bus (registered)
//   cfg_wr_vld       one-cycle strobe per applied register write
//   cfg_wr_addr      address of the applied write
//   cfg_wr_data      data of the applied write
//   err_cnt          saturating protocol error count
//
// Optional feature: define PIPE_MSGBUS_ERR_CNT_EN to build the error counter;
// otherwise err_cnt is tied to 8'h00.

module pipe_msgbus_phy_responder #(
  parameter int NUM_REGS   = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [7:0]  m2p_message_bus,
  output logic [7:0]  p2m_message_bus,
  output logic        cfg_wr_vld,
  output logic [11:0] cfg_wr_addr,
  output logic [7:0]  cfg_wr_data,
  output logic [7:0]  err_cnt
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam logic [CW-1:0] WB_FULL  = CW'(WBUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(WBUF_DEPTH - 1);

  localparam logic [3:0] CMD_WR_UNC = 4'h1;
  localparam logic [3:0] CMD_WR_COM = 4'h2;
  localparam logic [3:0] CMD_RD     = 4'h3;
  localparam logic [7:0] RC_HDR     = 8'h40;
  localparam logic [7:0] ACK_BYTE   = 8'h50;

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR_LO, RX_DATA} rx_state_t;
  typedef enum logic {TX_IDLE, TX_RC_DATA} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [3:0]  m2p_cmd;
  logic        cmd_start;
  logic [3:0]  rx_cmd_q;
  logic [3:0]  addr_hi_q;
  logic [7:0]  addr_lo_q;
  logic [11:0] rx_addr;
  logic        rd_now, wu_now, wc_now;

  logic [7:0]  regs [NUM_REGS];

  logic [11:0] wb_addr [WBUF_DEPTH];
  logic [7:0]  wb_data [WBUF_DEPTH];
  logic [PW-1:0] wb_rd_ptr, wb_wr_ptr;
  logic [CW-1:0] wb_count;
  logic        wb_push, wb_pop;

  logic        drain_active_q;
  logic [CW-1:0] drain_left_q;
  logic [11:0] commit_addr_q;
  logic [7:0]  commit_data_q;
  logic        wc_acc;
  logic        ack_now;
  logic        wr_in_range;

  logic        rc_pend_q, ack_pend_q;
  logic        rd_acc, rc_req, ack_req, rc_take, ack_take;
  logic [11:0] rd_addr_q;
  logic        rd_in_range;
  logic [7:0]  p2m_d;

  // ---------------------------------------------------------------- RX decode
  assign m2p_cmd   = m2p_message_bus[7:4];
  assign cmd_start = (rx_state == RX_IDLE) &&
                     (m2p_cmd == CMD_WR_UNC || m2p_cmd == CMD_WR_COM || m2p_cmd == CMD_RD);
  assign rx_addr   = {addr_hi_q, addr_lo_q};

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      rx_cmd_q  <= 4'h0;
      addr_hi_q <= 4'h0;
      addr_lo_q <= 8'h00;
    end else begin
      rx_state <= rx_next;
      if (cmd_start) begin
        rx_cmd_q  <= m2p_cmd;
        addr_hi_q <= m2p_message_bus[3:0];
      end
      if (rx_state == RX_ADDR_LO)
        addr_lo_q <= m2p_message_bus;
    end
  end

  // Only the IDLE byte is a command; ADDR_LO/DATA bytes are raw fields.
  always_comb begin
    rx_next = rx_state;
    rd_now  = 1'b0;
    wu_now  = 1'b0;
    wc_now  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (cmd_start)
          rx_next = RX_ADDR_LO;
      end
      RX_ADDR_LO: begin
        if (rx_cmd_q == CMD_RD) begin
          rx_next = RX_IDLE;
          rd_now  = 1'b1;
        end else begin
          rx_next = RX_DATA;
        end
      end
      RX_DATA: begin
        rx_next = RX_IDLE;
        wu_now  = (rx_cmd_q == CMD_WR_UNC);
        wc_now  = (rx_cmd_q == CMD_WR_COM);
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // ------------------------------------------------- uncommitted write FIFO
  // A push into a full buffer is dropped even if a drain pop happens in the
  // same cycle; the full test uses the registered count only.
  assign wb_push = wu_now && (wb_count != WB_FULL);
  assign wb_pop  = drain_active_q && (drain_left_q != '0);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      wb_rd_ptr <= '0;
      wb_wr_ptr <= '0;
      wb_count  <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr[i] <= 12'h000;
        wb_data[i] <= 8'h00;
      end
    end else begin
      if (wb_push) begin
        wb_addr[wb_wr_ptr] <= rx_addr;
        wb_data[wb_wr_ptr] <= m2p_message_bus;
        wb_wr_ptr <= (wb_wr_ptr == PTR_LAST) ? '0 : wb_wr_ptr + 1'b1;
      end
      if (wb_pop)
        wb_rd_ptr <= (wb_rd_ptr == PTR_LAST) ? '0 : wb_rd_ptr + 1'b1;
      case ({wb_push, wb_pop})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: wb_count <= wb_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- drain
  // drain_left_q is latched from the buffer occupancy when the committed
  // write's data byte arrives, so entries pushed during the drain stay put.
  assign wc_acc  = wc_now && !drain_active_q && !ack_pend_q;
  assign ack_now = drain_active_q && (drain_left_q == '0);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      drain_active_q <= 1'b0;
      drain_left_q   <= '0;
      commit_addr_q  <= 12'h000;
      commit_data_q  <= 8'h00;
    end else if (wc_acc) begin
      drain_active_q <= 1'b1;
      drain_left_q   <= wb_count;
      commit_addr_q  <= rx_addr;
      commit_data_q  <= m2p_message_bus;
    end else if (drain_active_q) begin
      if (drain_left_q != '0)
        drain_left_q <= drain_left_q - 1'b1;
      else
        drain_active_q <= 1'b0;
    end
  end

  // Strobe is driven straight from drain registers so it lands the cycle
  // after the committed data byte.
  always_comb begin
    cfg_wr_vld  = drain_active_q;
    cfg_wr_addr = 12'h000;
    cfg_wr_data = 8'h00;
    if (drain_active_q) begin
      if (drain_left_q != '0) begin
        cfg_wr_addr = wb_addr[wb_rd_ptr];
        cfg_wr_data = wb_data[wb_rd_ptr];
      end else begin
        cfg_wr_addr = commit_addr_q;
        cfg_wr_data = commit_data_q;
      end
    end
  end

  // ---------------------------------------------------------- register file
  assign wr_in_range = (int'(cfg_wr_addr) < NUM_REGS);
  assign rd_in_range = (int'(rd_addr_q) < NUM_REGS);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= 8'h00;
    end else if (cfg_wr_vld && wr_in_range) begin
      regs[cfg_wr_addr[RW-1:0]] <= cfg_wr_data;
    end
  end

  // -------------------------------------------------------------------- TX
  // Requests raised this cycle are served immediately when TX is idle so the
  // completion header / ack appear one cycle after the triggering event.
  assign rd_acc  = rd_now && !rc_pend_q;
  assign rc_req  = rc_pend_q || rd_acc;
  assign ack_req = ack_pend_q || ack_now;

  always_comb begin
    tx_next  = tx_state;
    p2m_d    = 8'h00;
    rc_take  = 1'b0;
    ack_take = 1'b0;
    if (tx_state == TX_IDLE) begin
      if (rc_req) begin
        p2m_d   = RC_HDR;
        tx_next = TX_RC_DATA;
        rc_take = 1'b1;
      end else if (ack_req) begin
        p2m_d    = ACK_BYTE;
        ack_take = 1'b1;
      end
    end else begin
      p2m_d   = rd_in_range ? regs[rd_addr_q[RW-1:0]] : 8'h00;
      tx_next = TX_IDLE;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      tx_state        <= TX_IDLE;
      p2m_message_bus <= 8'h00;
      rc_pend_q       <= 1'b0;
      ack_pend_q      <= 1'b0;
      rd_addr_q       <= 12'h000;
    end else begin
      tx_state        <= tx_next;
      p2m_message_bus <= p2m_d;
      rc_pend_q       <= rc_req && !rc_take;
      ack_pend_q      <= ack_req && !ack_take;
      if (rd_acc)
        rd_addr_q <= {addr_hi_q, m2p_message_bus};
    end
  end

  // ---------------------------------------------------------- error count
`ifdef PIPE_MSGBUS_ERR_CNT_EN
  logic       illegal_cmd, wb_overflow, rd_drop, wc_drop, err_event;
  logic [7:0] err_cnt_q;

  assign illegal_cmd = (rx_state == RX_IDLE) && (m2p_cmd > CMD_RD);
  assign wb_overflow = wu_now && (wb_count == WB_FULL);
  assign rd_drop     = rd_now && rc_pend_q;
  assign wc_drop     = wc_now && !wc_acc;
  // Several events in one cycle still count once.
  assign err_event   = illegal_cmd || wb_overflow || rd_drop || wc_drop;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset)
      err_cnt_q <= 8'h00;
    else if (err_event && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'h01;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
